note_sequencer: RTL and testbench

- Plays a programmed melody by stepping a 5-bit note index into the note-to-increment lookup (the jump/remainder table), which feeds the tone phase accumulator.
- Holds a 16-entry sequence memory of {rest, note, duration}.
- On command, walks the sequence at a fixed tempo, once or looped.
- Drives the current note index plus a gate that the audio output stage uses to mute between notes.

---
 rtl/note_sequencer.sv | 148 ++++++++++++++
 tb/tb_note_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - melody sequencer stepping a 16-entry {rest, note, dur} table at a fixed tempo
// Drives the note index and sound gate for the tone lookup/accumulator stage.
module note_sequencer #(
  parameter int TICK_DIV = 12500000,
  parameter int GAP      = 1250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [9:0] wr_data,
  input  logic [3:0] length,
  input  logic       loop,
  input  logic       play,
  input  logic       stop,
  output logic [4:0] note,
  output logic       gate,
  output logic [3:0] step,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(16 * TICK_DIV);
  localparam logic [CW-1:0] TD_C  = CW'(TICK_DIV);
  localparam logic [CW-1:0] GAP_C = CW'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    note_q, note_d;
  logic [3:0]    step_q, step_d;
  logic          gate_q, gate_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aud_q, aud_d;

  logic [9:0]    mem_q [16];

  // Memory is deliberately not reset; LOAD reads the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  logic [9:0]    entry;
  logic [4:0]    e_note;
  logic          e_valid, e_aud, last, cnt_zero, gap_hit;
  logic [CW-1:0] cnt_load;

  assign entry    = mem_q[step_q];
  assign e_note   = entry[8:4];
  assign e_valid  = (e_note <= 5'd23);
  assign e_aud    = e_valid & ~entry[9];
  assign cnt_load = (CW'(entry[3:0]) + CW'(1)) * TD_C - CW'(1);
  assign last     = (step_q == length);
  assign cnt_zero = (cnt_q == '0);
  assign gap_hit  = (GAP > 0) && (cnt_q == GAP_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      note_q  <= '0;
      step_q  <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aud_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      step_q  <= step_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      aud_q   <= aud_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (play && !stop) state_d = S_LOAD;
      S_LOAD, S_PLAY: begin
        if (stop)                   state_d = S_IDLE;
        else if (play)              state_d = S_LOAD;
        else if (state_q == S_LOAD) state_d = S_PLAY;
        else if (cnt_zero)          state_d = (!last || loop) ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    note_d = note_q;
    step_d = step_q;
    gate_d = gate_q;
    busy_d = busy_q;
    done_d = 1'b0;
    aud_d  = aud_q;
    case (state_q)
      S_IDLE: begin
        if (play && !stop) begin
          step_d = '0;
          busy_d = 1'b1;
        end
      end
      default: begin
        if (stop) begin
          gate_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (play) begin
          step_d = '0;
          gate_d = 1'b0;
        end else if (state_q == S_LOAD) begin
          note_d = e_valid ? e_note : 5'd0;
          gate_d = (GAP == 0) ? gate_q : e_aud;
          aud_d  = e_aud;
          cnt_d  = cnt_load;
        end else begin
          cnt_d = cnt_q - CW'(1);
          // Without an articulation gap the gate follows the step once LOAD is past (legato).
          if (GAP == 0)   gate_d = aud_q;
          else if (gap_hit) gate_d = 1'b0;
          if (cnt_zero) begin
            if (!last)     step_d = step_q + 4'd1;
            else if (loop) step_d = '0;
            else begin
              gate_d = 1'b0;
              busy_d = 1'b0;
              done_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign note = note_q;
  assign gate = gate_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer
// Timeline model: each step lasts (dur+1)*TD+1 cycles, gate high on cycles 1..P-1-GAP.
module tb_note_sequencer;
  localparam int TD = 4;
  localparam int GP = 1;

  logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [3:0] wr_addr = '0, length = '0;
  logic [9:0] wr_data = '0;
  logic       loop = 1'b0, play = 1'b0, stop = 1'b0;
  logic [4:0] note;
  logic [3:0] step;
  logic       gate, busy, done;

  note_sequencer #(.TICK_DIV(TD), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .length(length), .loop(loop), .play(play), .stop(stop),
    .note(note), .gate(gate), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [9:0] mmem [16];
  logic [9:0] m_e;
  bit m_busy, m_aud, m_gate, m_done;
  int m_step, m_j, m_p, m_note;
  bit chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_step = 0; m_j = 0; m_p = 1; m_aud = 0;
      m_note = 0; m_gate = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (play && !stop) begin m_busy = 1; m_step = 0; m_j = 0; m_gate = 0; end
      end else if (stop) begin
        m_busy = 0; m_gate = 0; m_done = 1;
      end else if (play) begin
        m_step = 0; m_j = 0; m_gate = 0;
      end else if (m_j == 0) begin
        m_e    = mmem[m_step];
        m_p    = (int'(m_e[3:0]) + 1) * TD + 1;
        m_aud  = !m_e[9] && (m_e[8:4] <= 23);
        m_note = (m_e[8:4] <= 23) ? int'(m_e[8:4]) : 0;
        m_j    = 1;
        m_gate = m_aud;
      end else if (m_j == m_p - 1) begin
        if (m_step != int'(length)) begin m_step = (m_step + 1) % 16; m_j = 0; end
        else if (loop) begin m_step = 0; m_j = 0; end
        else begin m_busy = 0; m_gate = 0; m_done = 1; end
      end else begin
        m_j++;
        m_gate = m_aud && (m_j <= m_p - 1 - GP);
      end
      if (wr_en) mmem[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("m_note", note, m_note);
      check("m_gate", gate, m_gate);
      check("m_step", step, m_step);
      check("m_busy", busy, m_busy);
      check("m_done", done, m_done);
    end
  end

  int ghigh [16];
  int lastnote [16];

  task automatic wr(input logic [3:0] a, input logic [9:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_play();
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
  endtask

  task automatic run(input int maxc, output int nbusy, output int ndone);
    nbusy = 0; ndone = 0;
    for (int s = 0; s < 16; s++) begin ghigh[s] = 0; lastnote[s] = -1; end
    pulse_play();
    for (int c = 0; c < maxc; c++) begin
      if (done) ndone++;
      if (!busy) break;
      nbusy++;
      lastnote[step] = int'(note);
      if (gate) ghigh[step]++;
      @(negedge clk);
    end
    check("run_bound", busy, 0);
  endtask

  int nb, nd, trans, pstep;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_note", note, 0);
    check("rst_gate", gate, 0);
    check("rst_step", step, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) wr(4'(i), {1'b0, 5'(i), 4'd0});
    chk_en = 1'b1;

    // single step, dur=1
    wr(4'd0, {1'b0, 5'd9, 4'd1});
    length = 4'd0; loop = 1'b0;
    pulse_play();
    check("t1_busy", busy, 1);
    check("t1_gate0", gate, 0);
    @(negedge clk);
    check("t1_note", note, 9);
    check("t1_gate_on", gate, 1);
    repeat (6) @(negedge clk);
    check("t1_gate_last", gate, 1);
    @(negedge clk);
    check("t1_gate_off", gate, 0);
    check("t1_busy_mid", busy, 1);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_note_hold", note, 9);

    // three steps
    wr(4'd0, {1'b0, 5'd0, 4'd0});
    wr(4'd1, {1'b0, 5'd12, 4'd0});
    wr(4'd2, {1'b0, 5'd23, 4'd0});
    length = 4'd2;
    run(60, nb, nd);
    check("t2_busy_cycles", nb, 15);
    check("t2_dones", nd, 1);
    for (int s = 0; s < 3; s++) check("t2_gate_cycles", ghigh[s], 3);
    check("t2_note1", lastnote[1], 12);
    check("t2_note2", lastnote[2], 23);

    // rest and out-of-range
    wr(4'd0, {1'b0, 5'd3, 4'd0});
    wr(4'd1, {1'b1, 5'd5, 4'd0});
    wr(4'd2, {1'b0, 5'd30, 4'd0});
    run(60, nb, nd);
    check("t3_busy_cycles", nb, 15);
    check("t3_gate0", ghigh[0], 3);
    check("t3_gate_rest", ghigh[1], 0);
    check("t3_gate_oor", ghigh[2], 0);
    check("t3_note_rest", lastnote[1], 5);
    check("t3_note_oor", lastnote[2], 0);

    // loop, then stop mid-step
    loop = 1'b1; length = 4'd1;
    pulse_play();
    nd = 0; trans = 0; pstep = 0;
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (int'(step) != pstep) trans++;
      pstep = int'(step);
    end
    check("t4_no_done", nd, 0);
    check("t4_transitions", trans, 6);
    check("t4_pre_step", step, 0);
    check("t4_pre_gate", gate, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_stop_gate", gate, 0);
    check("t4_stop_busy", busy, 0);
    check("t4_stop_done", done, 1);
    check("t4_stop_note", note, 3);
    check("t4_stop_step", step, 0);
    @(negedge clk);
    check("t4_done_pulse", done, 0);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_idle_stop", done, 0);

    // play+stop while busy, then restart
    loop = 1'b0; length = 4'd2;
    pulse_play();
    repeat (3) @(negedge clk);
    play = 1'b1; stop = 1'b1;
    @(negedge clk);
    play = 1'b0; stop = 1'b0;
    check("t5_stopwins_busy", busy, 0);
    check("t5_stopwins_done", done, 1);
    pulse_play();
    repeat (7) @(negedge clk);
    check("t5_mid_step", step, 1);
    pulse_play();
    check("t5_restart_step", step, 0);
    check("t5_restart_gate", gate, 0);
    check("t5_restart_busy", busy, 1);
    @(negedge clk);
    check("t5_reload_note", note, 3);
    check("t5_reload_gate", gate, 1);
    repeat (20) @(negedge clk);

    // asynchronous reset mid-play
    pulse_play();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_gate", gate, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_note", note, 0);
    check("t6_rst_step", step, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_play();
    @(negedge clk);
    check("t6_replay_note", note, 3);
    check("t6_replay_gate", gate, 1);
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    check("t6_end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
